// File: rtl/lane_striper.sv
// Two-lane byte striper: a DEPTH-entry FIFO feeding two registered lanes round-robin.
// Optional sticky overflow detection is built when LANE_STRIPER_OVF_EN is defined.
module lane_striper #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_f,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               data_in,
    input  logic                     valid_in,
    output logic                     in_ready,
    output logic [7:0]               data_out_0,
    output logic [7:0]               data_out_1,
    output logic                     valid_out_0,
    output logic                     valid_out_1,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_p1;
    logic          nl;

    logic          push;
    logic [1:0]    pop_n;
    logic          ld0;
    logic          ld1;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic          nl_nxt;
    logic [CW-1:0] count_nxt;

    assign in_ready  = (fifo_count < CW'(DEPTH));
    assign push      = valid_in && in_ready;
    assign rd_ptr_p1 = rd_ptr + AW'(1);

    // Pop decision uses the pre-edge count, so a same-edge push is never popped.
    always_comb begin
        pop_n     = 2'd0;
        ld0       = 1'b0;
        ld1       = 1'b0;
        d0        = data_out_0;
        d1        = data_out_1;
        nl_nxt    = nl;
        if (enable) begin
            if (fifo_count == CW'(0))
                pop_n = 2'd0;
            else if (fifo_count == CW'(1))
                pop_n = 2'd1;
            else
                pop_n = 2'd2;
        end
        if (pop_n != 2'd0) begin
            if (!nl) begin
                ld0 = 1'b1;
                d0  = mem[rd_ptr];
            end else begin
                ld1 = 1'b1;
                d1  = mem[rd_ptr];
            end
        end
        if (pop_n == 2'd2) begin
            if (!nl) begin
                ld1 = 1'b1;
                d1  = mem[rd_ptr_p1];
            end else begin
                ld0 = 1'b1;
                d0  = mem[rd_ptr_p1];
            end
        end
        if (pop_n == 2'd1)
            nl_nxt = ~nl;
        count_nxt = fifo_count + CW'(push) - CW'(pop_n);
    end

    // Storage has no reset; clearing the pointers discards the contents.
    always_ff @(posedge clk_f) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            nl          <= 1'b0;
            data_out_0  <= 8'h00;
            data_out_1  <= 8'h00;
            valid_out_0 <= 1'b0;
            valid_out_1 <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_ptr + AW'(pop_n);
            fifo_count  <= count_nxt;
            nl          <= nl_nxt;
            data_out_0  <= d0;
            data_out_1  <= d1;
            valid_out_0 <= ld0;
            valid_out_1 <= ld1;
        end
    end

`ifdef LANE_STRIPER_OVF_EN
    // Sticky until reset: a byte offered while full is dropped and flagged.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset)
            overflow_err <= 1'b0;
        else if (valid_in && (fifo_count == CW'(DEPTH)))
            overflow_err <= 1'b1;
    end
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_lane_striper.sv
// Directed self-checking bench for lane_striper (DEPTH=4), one task per scenario.
module tb_lane_striper;

    logic       clk_f = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       in_ready;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic       valid_out_0;
    logic       valid_out_1;
    logic [2:0] fifo_count;
    logic       overflow_err;

    int total = 0;
    int bad   = 0;

`ifdef LANE_STRIPER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    lane_striper #(.DEPTH(4)) dut (
        .clk_f(clk_f), .reset(reset), .enable(enable), .data_in(data_in),
        .valid_in(valid_in), .in_ready(in_ready), .data_out_0(data_out_0),
        .data_out_1(data_out_1), .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
        .fifo_count(fifo_count), .overflow_err(overflow_err)
    );

    always #5 clk_f = ~clk_f;

    task automatic step();
        @(posedge clk_f);
        #1;
    endtask

    task automatic push_bytes_disabled(input logic [7:0] b0, input int n);
        enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            data_in  = b0 + 8'(i);
            step();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b1; data_in = 8'hEE; enable = 1'b1;
        step(); step();
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if ({valid_out_0, valid_out_1} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%b exp=00", {valid_out_0, valid_out_1}); end
        total++; if ({data_out_0, data_out_1} !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", {data_out_0, data_out_1}); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
        valid_in = 1'b0; enable = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic_stripe();
        logic [7:0] b [4];
        logic [7:0] seen [$];
        int j;
        logic e0, e1;
        logic [2:0] ec;
        b[0] = 8'hA1; b[1] = 8'hA2; b[2] = 8'hA3; b[3] = 8'hA4;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_in = (i < 4);
            if (i < 4) data_in = b[i];
            step();
            j  = i - 1;
            e0 = (j >= 0) && (j < 4) && (j % 2 == 0);
            e1 = (j >= 0) && (j < 4) && (j % 2 == 1);
            ec = (i < 4) ? 3'd1 : 3'd0;
            total++; if (valid_out_0 !== e0) begin bad++; $display("FAIL stripe_v0 cyc=%0d got=%b exp=%b", i, valid_out_0, e0); end
            total++; if (valid_out_1 !== e1) begin bad++; $display("FAIL stripe_v1 cyc=%0d got=%b exp=%b", i, valid_out_1, e1); end
            total++; if (fifo_count !== ec) begin bad++; $display("FAIL stripe_count cyc=%0d got=%0d exp=%0d", i, fifo_count, ec); end
            if (e0) begin
                total++; if (data_out_0 !== b[j]) begin bad++; $display("FAIL stripe_d0 cyc=%0d got=%h exp=%h", i, data_out_0, b[j]); end
            end
            if (e1) begin
                total++; if (data_out_1 !== b[j]) begin bad++; $display("FAIL stripe_d1 cyc=%0d got=%h exp=%h", i, data_out_1, b[j]); end
            end
            if (valid_out_0) seen.push_back(data_out_0);
            if (valid_out_1) seen.push_back(data_out_1);
        end
        total++; if (seen.size() != 4) begin bad++; $display("FAIL stripe_order_len got=%0d exp=4", seen.size()); end
        else for (int k = 0; k < 4; k++) begin
            total++; if (seen[k] !== b[k]) begin bad++; $display("FAIL stripe_order idx=%0d got=%h exp=%h", k, seen[k], b[k]); end
        end
    endtask

    task automatic test_burst_hold();
        push_bytes_disabled(8'h10, 4);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL burst_count got=%0d exp=4", fifo_count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL burst_in_ready got=%b exp=0", in_ready); end
        total++; if ({valid_out_0, valid_out_1} !== 2'b00) begin bad++; $display("FAIL burst_hold_valids got=%b exp=00", {valid_out_0, valid_out_1}); end
        enable = 1'b1;
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0, data_out_1} !== {2'b11, 16'h1011}) begin bad++; $display("FAIL burst_pair1 got=%b%b %h %h exp=11 10 11", valid_out_0, valid_out_1, data_out_0, data_out_1); end
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL burst_count2 got=%0d exp=2", fifo_count); end
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0, data_out_1} !== {2'b11, 16'h1213}) begin bad++; $display("FAIL burst_pair2 got=%b%b %h %h exp=11 12 13", valid_out_0, valid_out_1, data_out_0, data_out_1); end
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0, data_out_1} !== {2'b00, 16'h1213}) begin bad++; $display("FAIL burst_empty_hold got=%b%b %h %h exp=00 12 13", valid_out_0, valid_out_1, data_out_0, data_out_1); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL burst_count0 got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_odd_byte();
        push_bytes_disabled(8'h55, 1);
        push_bytes_disabled(8'h66, 1);
        push_bytes_disabled(8'h77, 1);
        enable = 1'b1;
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0, data_out_1} !== {2'b11, 16'h5566}) begin bad++; $display("FAIL odd_pair got=%b%b %h %h exp=11 55 66", valid_out_0, valid_out_1, data_out_0, data_out_1); end
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0} !== {2'b10, 8'h77}) begin bad++; $display("FAIL odd_lone got=%b%b %h exp=10 77", valid_out_0, valid_out_1, data_out_0); end
        valid_in = 1'b1; data_in = 8'h88;
        step();
        valid_in = 1'b0;
        total++; if ({valid_out_0, valid_out_1} !== 2'b00) begin bad++; $display("FAIL odd_same_edge got=%b%b exp=00", valid_out_0, valid_out_1); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL odd_count got=%0d exp=1", fifo_count); end
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_1} !== {2'b01, 8'h88}) begin bad++; $display("FAIL odd_lane1 got=%b%b %h exp=01 88", valid_out_0, valid_out_1, data_out_1); end
    endtask

    task automatic test_overflow();
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b exp=0", overflow_err); end
        push_bytes_disabled(8'h01, 5);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        total++; if (overflow_err !== OVF_EXP) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", overflow_err, OVF_EXP); end
        enable = 1'b1;
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0, data_out_1} !== {2'b11, 16'h0102}) begin bad++; $display("FAIL ovf_drain1 got=%b%b %h %h exp=11 01 02", valid_out_0, valid_out_1, data_out_0, data_out_1); end
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0, data_out_1} !== {2'b11, 16'h0304}) begin bad++; $display("FAIL ovf_drain2 got=%b%b %h %h exp=11 03 04", valid_out_0, valid_out_1, data_out_0, data_out_1); end
        step();
        total++; if ({valid_out_0, valid_out_1, fifo_count} !== {2'b00, 3'd0}) begin bad++; $display("FAIL ovf_drained got=%b%b cnt=%0d exp=00 cnt=0", valid_out_0, valid_out_1, fifo_count); end
        total++; if (overflow_err !== OVF_EXP) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", overflow_err, OVF_EXP); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        valid_in = 1'b1; data_in = 8'h9A;
        step();
        valid_in = 1'b0;
        step();
        push_bytes_disabled(8'hB0, 3);
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL mid_count_pre got=%0d exp=3", fifo_count); end
        #2 reset = 1'b1;
        #1;
        total++; if ({fifo_count, valid_out_0, valid_out_1, data_out_0, data_out_1, overflow_err} !== 22'd0) begin bad++; $display("FAIL mid_async_clear cnt=%0d v=%b%b d=%h %h ovf=%b exp all 0", fifo_count, valid_out_0, valid_out_1, data_out_0, data_out_1, overflow_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        step();
        reset = 1'b0;
        enable = 1'b1; valid_in = 1'b1; data_in = 8'hC3;
        step();
        valid_in = 1'b0;
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL mid_first_push got=%0d exp=1", fifo_count); end
        step();
        total++; if ({valid_out_0, valid_out_1, data_out_0} !== {2'b10, 8'hC3}) begin bad++; $display("FAIL mid_c3_lane0 got=%b%b %h exp=10 c3", valid_out_0, valid_out_1, data_out_0); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count_end got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_stripe();
        test_burst_hold();
        test_odd_byte();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
